// File: rtl/note_chart_feeder_pkg.sv
// Shared definitions for the note-chart feeder.
// Purpose : feeder state encoding, default game timing and the saturating
//           step-count helper.
// Ports   : none (package).
package note_chart_feeder_pkg;

  localparam int SHIFTER_DEPTH          = 100;
  localparam int DEFAULT_TICKS_PER_STEP = 833333;
  localparam int STEP_COUNT_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
    ST_RUN   = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } feeder_state_t;

  function automatic logic [STEP_COUNT_W-1:0] sat_inc(input logic [STEP_COUNT_W-1:0] v);
    return (v == '1) ? v : v + STEP_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/note_chart_feeder_step_timer.sv
// Enable-gated mod-TICKS counter with a terminal-count pulse.
// Purpose : paces shift steps; holds its count while enable is low, so a
//           terminal count that is reached while disabled fires on the first
//           enabled cycle.
// Ports   : clock, reset_n (async, active low)
//           clear  - synchronous return to zero (wins over enable)
//           enable - advance the count this cycle
//           tick   - high in the enabled cycle where the count is TICKS-1
module note_chart_feeder_step_timer #(
  parameter int TICKS = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_chart_feeder.sv
// Writer side of the note shifter.
// Purpose : reads chart words from a synchronous ROM and serialises them MSB
//           first onto the shifter's in/shift/load_n inputs, one bit per step,
//           then appends FLUSH_STEPS zero steps so the last notes reach the
//           far end of the shifter.
// Ports   : clock, reset_n (async, active low)
//           start      - level, begins a play from IDLE or DONE
//           pause      - level, freezes step timing
//           rom_addr   - chart ROM address (registered)
//           rom_data   - ROM word, valid one cycle after rom_addr
//           shift_in   - serial bit, only non-zero alongside shift
//           shift      - one-cycle step pulse
//           load_n     - one-cycle low pulse clearing the shifter
//           busy, done - play in progress / play finished
//           step_count - steps emitted this play, saturating
//
// state | meaning
// IDLE  | waiting for start after reset
// CLEAR | load_n low for one cycle, address/step count/timer zeroed
// FETCH | ROM address presented, waiting for the ROM read
// LATCH | ROM word captured into word_reg
// RUN   | emitting word_reg bits, one per timer tick
// FLUSH | emitting zero steps until FLUSH_STEPS have been sent
// DONE  | play finished, start relaunches
module note_chart_feeder
  import note_chart_feeder_pkg::*;
#(
  parameter int WORD_W         = 10,
  parameter int ADDR_W         = 8,
  parameter int CHART_LEN      = 200,
  parameter int TICKS_PER_STEP = DEFAULT_TICKS_PER_STEP,
  parameter int FLUSH_STEPS    = SHIFTER_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    pause,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [WORD_W-1:0]       rom_data,
  output logic                    shift_in,
  output logic                    shift,
  output logic                    load_n,
  output logic                    busy,
  output logic                    done,
  output logic [STEP_COUNT_W-1:0] step_count
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FL_W  = (FLUSH_STEPS > 0) ? $clog2(FLUSH_STEPS + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CHART_LEN - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(WORD_W - 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_STEPS);

  feeder_state_t state, state_nx;

  logic [WORD_W-1:0]       word_reg, word_nx;
  logic [BIT_W-1:0]        bit_idx, bit_nx;
  logic [FL_W-1:0]         flush_cnt, flush_nx;
  logic [ADDR_W-1:0]       addr_nx;
  logic [STEP_COUNT_W-1:0] step_nx;
  logic                    shift_nx, shift_in_nx, load_n_nx, busy_nx, done_nx;
  logic                    start_play, timer_en, step_tick;

  // Timing runs from CLEAR onward so the first step lands exactly
  // TICKS_PER_STEP cycles after the load_n pulse; FETCH/LATCH sit inside the
  // step period instead of stretching it.
  assign timer_en = (state != ST_IDLE) && (state != ST_DONE) && !pause;

  note_chart_feeder_step_timer #(
    .TICKS (TICKS_PER_STEP)
  ) u_step_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_play),
    .enable  (timer_en),
    .tick    (step_tick)
  );

  always_comb begin
    state_nx    = state;
    addr_nx     = rom_addr;
    word_nx     = word_reg;
    bit_nx      = bit_idx;
    flush_nx    = flush_cnt;
    step_nx     = step_count;
    shift_nx    = 1'b0;
    shift_in_nx = 1'b0;
    start_play  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx   = ST_CLEAR;
          start_play = 1'b1;
          addr_nx    = '0;
          step_nx    = '0;
          flush_nx   = '0;
        end
      end
      ST_CLEAR: state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: begin
        word_nx  = rom_data;
        bit_nx   = '0;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (step_tick) begin
          shift_nx    = 1'b1;
          shift_in_nx = word_reg[WORD_W-1];
          word_nx     = word_reg << 1;
          step_nx     = sat_inc(step_count);
          if (bit_idx == LAST_BIT) begin
            if (rom_addr == LAST_ADDR) begin
              state_nx = ST_FLUSH;
            end else begin
              addr_nx  = rom_addr + ADDR_W'(1);
              state_nx = ST_FETCH;
            end
          end else begin
            bit_nx = bit_idx + BIT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        // One idle FLUSH cycle after the last step keeps busy high through it.
        if (flush_cnt == FLUSH_LAST) begin
          state_nx = ST_DONE;
        end else if (step_tick) begin
          shift_nx = 1'b1;
          step_nx  = sat_inc(step_count);
          flush_nx = flush_cnt + FL_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    load_n_nx = (state_nx != ST_CLEAR);
    busy_nx   = (state_nx != ST_IDLE) && (state_nx != ST_DONE);
    done_nx   = (state_nx == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      word_reg   <= '0;
      bit_idx    <= '0;
      flush_cnt  <= '0;
      step_count <= '0;
      shift      <= 1'b0;
      shift_in   <= 1'b0;
      load_n     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      rom_addr   <= addr_nx;
      word_reg   <= word_nx;
      bit_idx    <= bit_nx;
      flush_cnt  <= flush_nx;
      step_count <= step_nx;
      shift      <= shift_nx;
      shift_in   <= shift_in_nx;
      load_n     <= load_n_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_note_chart_feeder.sv
// Self-checking bench for note_chart_feeder with a small chart.
// Purpose : drives start/pause, models the chart ROM, and compares every
//           cycle against a step-level reference model (bit list + count of
//           unpaused cycles since the play began).
// Ports   : none (top-level bench).
module tb_note_chart_feeder;

  localparam int WORD_W    = 4;
  localparam int ADDR_W    = 2;
  localparam int CHART_LEN = 2;
  localparam int TICKS     = 4;
  localparam int FLUSH     = 3;
  localparam int TOTAL     = CHART_LEN * WORD_W + FLUSH;
  localparam logic [TOTAL-1:0] DIR_BITS = 11'b10100011000;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              shift_in, shift, load_n, busy, done;
  logic [15:0]       step_count;

  logic [WORD_W-1:0] rom [4];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit m_play = 1'b0;
  bit m_done = 1'b0;
  int m_en = 0;
  int m_steps = 0;
  bit m_bits [TOTAL];

  logic [20:0] obs_v, exp_v;

  always #5 clock = ~clock;

  always_ff @(posedge clock) rom_data <= rom[rom_addr];

  note_chart_feeder #(
    .WORD_W         (WORD_W),
    .ADDR_W         (ADDR_W),
    .CHART_LEN      (CHART_LEN),
    .TICKS_PER_STEP (TICKS),
    .FLUSH_STEPS    (FLUSH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .shift_in   (shift_in),
    .shift      (shift),
    .load_n     (load_n),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  task automatic model_reset();
    m_play = 1'b0; m_done = 1'b0; m_en = 0; m_steps = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, sample at negedge.
  // Step k of a play fires after the k*TICKS-th unpaused cycle following start.
  task automatic tick(input logic st, input logic pa);
    logic e_load, e_shift, e_sin;
    start = st;
    pause = pa;
    @(posedge clock);
    e_load = 1'b1; e_shift = 1'b0; e_sin = 1'b0;
    if (m_play) begin
      if (m_steps == TOTAL) begin
        m_play = 1'b0;
        m_done = 1'b1;
      end else if (!pa) begin
        m_en++;
        if (m_en % TICKS == 0) begin
          e_shift = 1'b1;
          e_sin   = m_bits[m_steps];
          m_steps++;
        end
      end
    end else if (st) begin
      m_play = 1'b1; m_done = 1'b0; m_en = 0; m_steps = 0; e_load = 1'b0;
      for (int i = 0; i < TOTAL; i++)
        m_bits[i] = (i < CHART_LEN * WORD_W) ? rom[i / WORD_W][WORD_W - 1 - (i % WORD_W)] : 1'b0;
    end
    exp_v = {e_load, e_shift, e_sin, logic'(m_play), logic'(m_done), 16'(m_steps)};
    @(negedge clock);
    obs_v = {load_n, shift, shift_in, busy, done, step_count};
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clock);
    obs_v = {load_n, shift, shift_in, busy, done, step_count};
    tests++;
    if (obs_v !== 21'h100000) begin
      fails++; $display("FAIL reset_outputs: got %b want %b", obs_v, 21'h100000);
    end
    tests++;
    if (rom_addr !== 2'd0) begin
      fails++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);
    end
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      tick(1'b0, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_directed();
    int load_cyc = 0, first_off = -1, npulse = 0, nload = 0;
    logic [TOTAL-1:0] seen = '0;
    rom[0] = 4'b1010; rom[1] = 4'b0011; rom[2] = 4'b1111; rom[3] = 4'b1111;
    for (int n = 0; n < 120; n++) begin
      tick(n == 0, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL directed_cycle %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (!load_n) begin nload++; load_cyc = cyc; end
      if (shift) begin
        if (npulse == 0) first_off = cyc - load_cyc;
        seen = {seen[TOTAL-2:0], shift_in};
        npulse++;
      end
      if (m_done) break;
    end
    tests++;
    if (nload !== 1) begin fails++; $display("FAIL directed_load_cycles: got %0d want 1", nload); end
    tests++;
    if (first_off !== TICKS) begin fails++; $display("FAIL directed_first_offset: got %0d want %0d", first_off, TICKS); end
    tests++;
    if (npulse !== TOTAL) begin fails++; $display("FAIL directed_pulses: got %0d want %0d", npulse, TOTAL); end
    tests++;
    if (seen !== DIR_BITS) begin fails++; $display("FAIL directed_bits: got %b want %b", seen, DIR_BITS); end
    tests++;
    if ({done, busy, step_count} !== {1'b1, 1'b0, 16'd11}) begin
      fails++; $display("FAIL directed_end: got done=%b busy=%b count=%0d want 1 0 11", done, busy, step_count);
    end
  endtask

  task automatic test_pause();
    int load_cyc = 0, npulse = 0, pcnt = 0, off3 = -1, off_last = -1;
    logic pa;
    for (int n = 0; n < 140; n++) begin
      pa = (npulse == 2) && (pcnt < 6);
      if (pa) pcnt++;
      tick(n == 0, pa);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL pause_cycle %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (!load_n) load_cyc = cyc;
      if (shift) begin
        npulse++;
        if (npulse == 3) off3 = cyc - load_cyc;
        if (npulse == TOTAL) off_last = cyc - load_cyc;
      end
      if (m_done) break;
    end
    tests++;
    if (off3 !== 3 * TICKS + 6) begin fails++; $display("FAIL pause_third_offset: got %0d want %0d", off3, 3 * TICKS + 6); end
    tests++;
    if (off_last !== TOTAL * TICKS + 6) begin fails++; $display("FAIL pause_last_offset: got %0d want %0d", off_last, TOTAL * TICKS + 6); end
  endtask

  task automatic test_start_busy();
    int npulse = 0, nload = 0;
    logic [TOTAL-1:0] seen = '0;
    for (int n = 0; n < 120; n++) begin
      tick((n == 0) || (npulse >= 3 && npulse <= 5), 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL start_busy_cycle %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (!load_n) nload++;
      if (shift) begin seen = {seen[TOTAL-2:0], shift_in}; npulse++; end
      if (m_done) break;
    end
    tests++;
    if (nload !== 1) begin fails++; $display("FAIL start_busy_loads: got %0d want 1", nload); end
    tests++;
    if (seen !== DIR_BITS || npulse !== TOTAL) begin
      fails++; $display("FAIL start_busy_bits: got %b (%0d pulses) want %b", seen, npulse, DIR_BITS);
    end
  endtask

  task automatic test_restart_from_done();
    int done_cyc = -1, npulse = 0;
    logic first_load = 1'b1, relaunched = 1'b0;
    for (int n = 0; n < 120; n++) begin
      tick(1'b1, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL restart_cycle %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (n == 0) first_load = load_n;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin relaunched = !load_n; break; end
    end
    tests++;
    if (first_load !== 1'b0) begin fails++; $display("FAIL restart_first_load_n: got %b want 0", first_load); end
    tests++;
    if (relaunched !== 1'b1) begin fails++; $display("FAIL restart_held_start: got %b want 1", relaunched); end
    for (int n = 0; n < 120; n++) begin
      tick(1'b0, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL replay_cycle %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (shift) npulse++;
      if (m_done) break;
    end
    tests++;
    if (npulse !== TOTAL) begin fails++; $display("FAIL replay_pulses: got %0d want %0d", npulse, TOTAL); end
  endtask

  task automatic test_reset_mid_play();
    int npulse = 0;
    logic [TOTAL-1:0] seen = '0;
    for (int n = 0; n < 60; n++) begin
      tick(n == 0, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL midreset_pre cyc %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (shift) npulse++;
      if (npulse == 2) break;
    end
    #2 reset_n = 1'b0;
    #1 obs_v = {load_n, shift, shift_in, busy, done, step_count};
    tests++;
    if (obs_v !== 21'h100000 || rom_addr !== 2'd0) begin
      fails++; $display("FAIL midreset_async: got %b addr %0d want %b addr 0", obs_v, rom_addr, 21'h100000);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    npulse = 0;
    for (int n = 0; n < 120; n++) begin
      tick(n == 1, 1'b0);
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL midreset_replay cyc %0d: got %b want %b", cyc, obs_v, exp_v);
      end
      if (shift) begin seen = {seen[TOTAL-2:0], shift_in}; npulse++; end
      if (m_done) break;
    end
    tests++;
    if (seen !== DIR_BITS || npulse !== TOTAL) begin
      fails++; $display("FAIL midreset_bits: got %b (%0d pulses) want %b", seen, npulse, DIR_BITS);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 4; a++) rom[a] = WORD_W'($urandom);
      for (int n = 0; n < 400; n++) begin
        tick((n == 0) || ($urandom_range(0, 7) == 0), $urandom_range(0, 3) == 0);
        tests++;
        if (obs_v !== exp_v) begin
          fails++; $display("FAIL random_%0d cyc %0d: got %b want %b", it, cyc, obs_v, exp_v);
        end
        if (m_done) break;
      end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL random_%0d_done: got %b want 1", it, done); end
      for (int n = 0; n < $urandom_range(1, 4); n++) begin
        tick(1'b0, $urandom_range(0, 1) == 1);
        tests++;
        if (obs_v !== exp_v) begin
          fails++; $display("FAIL random_%0d_idle cyc %0d: got %b want %b", it, cyc, obs_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4; a++) rom[a] = '0;
    test_reset();
    test_directed();
    test_pause();
    test_start_busy();
    test_restart_from_done();
    test_reset_mid_play();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
